// File: rtl/gf180mcu_osu_sc_gp12t3v3__tbuf_arb4.sv
// Round-robin owner controller for four tbuf_4 drivers sharing one net, with a break-before-make gap on handoff.
// Optional tenure limit: define GF180_TBUF_ARB_MAXHOLD_EN to preempt an owner after MAX_HOLD cycles when others wait.
module gf180mcu_osu_sc_gp12t3v3__tbuf_arb4 #(
   parameter int DEAD_CYCLES = 1,
   parameter int MAX_HOLD    = 16
) (
   input  logic       CLK,
   input  logic       RN,
   input  logic [3:0] REQ,
   output logic [3:0] EN,
   output logic [3:0] EN_BAR,
   output logic [3:0] GNT,
   output logic       BUSY
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_DEAD  = 2'd2;

   localparam logic [2:0] DEAD_LOAD = 3'(DEAD_CYCLES);

   if (DEAD_CYCLES < 1 || DEAD_CYCLES > 7 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
      $error("tbuf_arb4: DEAD_CYCLES or MAX_HOLD out of range");
   end

   logic [1:0] state_reg, state_next;
   logic [3:0] en_reg, en_next;
   logic [3:0] en_bar_reg;
   logic [1:0] last_owner_reg, last_owner_next;
   logic [2:0] dead_cnt_reg, dead_cnt_next;
   logic       busy_reg, busy_next;

   logic       win_valid;
   logic [1:0] win_idx;
   logic [1:0] cand;
   logic [3:0] win_onehot;
   logic       grant;
   logic       release_now;
   logic       preempt;

   // Walk from the farthest candidate to the nearest so the one right after last_owner wins;
   // the last owner itself comes up at k=4, i.e. lowest priority.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = last_owner_reg;
      cand      = last_owner_reg;
      for (int k = 4; k >= 1; k--) begin
         cand = last_owner_reg + 2'(k);
         if (REQ[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == 2'(gi));
   end

`ifdef GF180_TBUF_ARB_MAXHOLD_EN
   logic [7:0] hold_cnt_reg, hold_cnt_next;
   logic [8:0] hold_inc;
   logic       hold_limit;
   logic       others_waiting;

   assign hold_inc       = {1'b0, hold_cnt_reg} + 9'd1;
   assign hold_limit     = (hold_inc >= 9'(MAX_HOLD));
   assign others_waiting = |(REQ & ~en_reg);
   assign preempt        = (state_reg == ST_DRIVE) && hold_limit && others_waiting;

   // Saturate at MAX_HOLD so a late-arriving requester still triggers preemption at once.
   always_comb begin
      hold_cnt_next = hold_cnt_reg;
      if (grant)
         hold_cnt_next = 8'd0;
      else if (state_reg == ST_DRIVE)
         hold_cnt_next = hold_limit ? 8'(MAX_HOLD) : hold_inc[7:0];
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN)
         hold_cnt_reg <= 8'd0;
      else
         hold_cnt_reg <= hold_cnt_next;
   end
`else
   assign preempt = 1'b0;
`endif

   assign release_now = !REQ[last_owner_reg] || preempt;

   always_comb begin
      state_next      = state_reg;
      en_next         = en_reg;
      last_owner_next = last_owner_reg;
      dead_cnt_next   = dead_cnt_reg;
      grant           = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (win_valid) begin
               grant           = 1'b1;
               en_next         = win_onehot;
               last_owner_next = win_idx;
               state_next      = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (release_now) begin
               en_next       = 4'b0000;
               dead_cnt_next = DEAD_LOAD;
               state_next    = ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (dead_cnt_reg <= 3'd1) begin
               dead_cnt_next = 3'd0;
               if (win_valid) begin
                  grant           = 1'b1;
                  en_next         = win_onehot;
                  last_owner_next = win_idx;
                  state_next      = ST_DRIVE;
               end else begin
                  en_next    = 4'b0000;
                  state_next = ST_IDLE;
               end
            end else begin
               dead_cnt_next = dead_cnt_reg - 3'd1;
            end
         end
         default: begin
            en_next    = 4'b0000;
            state_next = ST_IDLE;
         end
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_reg      <= ST_IDLE;
         en_reg         <= 4'b0000;
         en_bar_reg     <= 4'b1111;
         last_owner_reg <= 2'd3;
         dead_cnt_reg   <= 3'd0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         en_reg         <= en_next;
         en_bar_reg     <= ~en_next;
         last_owner_reg <= last_owner_next;
         dead_cnt_reg   <= dead_cnt_next;
         busy_reg       <= busy_next;
      end
   end

   assign EN     = en_reg;
   assign EN_BAR = en_bar_reg;
   assign GNT    = en_reg;
   assign BUSY   = busy_reg;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__tbuf_arb4.sv
// Directed bench for the tbuf_4 bus-ownership controller: one instance with a 3-cycle gap, one with a 1-cycle gap.
module tb_gf180mcu_osu_sc_gp12t3v3__tbuf_arb4;

   logic       clk;
   logic       rn;
   logic [3:0] req3, en3, en_bar3, gnt3;
   logic       busy3;
   logic [3:0] req1, en1, en_bar1, gnt1;
   logic       busy1;

   int n_checks = 0;
   int n_fail   = 0;

   gf180mcu_osu_sc_gp12t3v3__tbuf_arb4 #(.DEAD_CYCLES(3), .MAX_HOLD(4)) u_dut3 (
      .CLK(clk), .RN(rn), .REQ(req3), .EN(en3), .EN_BAR(en_bar3), .GNT(gnt3), .BUSY(busy3)
   );

   gf180mcu_osu_sc_gp12t3v3__tbuf_arb4 #(.DEAD_CYCLES(1), .MAX_HOLD(4)) u_dut1 (
      .CLK(clk), .RN(rn), .REQ(req1), .EN(en1), .EN_BAR(en_bar1), .GNT(gnt1), .BUSY(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Structural invariants sampled away from the active edge every cycle.
   always @(negedge clk) begin
      chk("pop3", ($countones(en3) <= 1) ? 32'd1 : 32'd0, 32'd1);
      chk("enbar3", {28'd0, en_bar3}, {28'd0, ~en3});
      chk("gnt3", {28'd0, gnt3}, {28'd0, en3});
      chk("pop1", ($countones(en1) <= 1) ? 32'd1 : 32'd0, 32'd1);
      chk("enbar1", {28'd0, en_bar1}, {28'd0, ~en1});
   end

   initial begin
      logic [3:0] exp_en;
      rn   = 1'b0;
      req3 = 4'b0000;
      req1 = 4'b0000;
      tick();
      tick();
      chk("rst_en", {28'd0, en3}, 32'h0);
      chk("rst_enbar", {28'd0, en_bar3}, 32'hF);
      chk("rst_gnt", {28'd0, gnt3}, 32'h0);
      chk("rst_busy", {31'd0, busy3}, 32'h0);

      // Grant from IDLE: one-cycle latency.
      rn   = 1'b1;
      req3 = 4'b0100;
      tick();
      chk("idle_grant_en", {28'd0, en3}, 32'h4);
      chk("idle_grant_enbar", {28'd0, en_bar3}, 32'hB);
      chk("idle_grant_busy", {31'd0, busy3}, 32'h1);
      tick();
      chk("hold2_en", {28'd0, en3}, 32'h4);

      // Owner 2 drops while 0 and 3 request: gap of 3, then index 3.
      req3 = 4'b1001;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("gap3_%0d", i), {28'd0, en3}, 32'h0);
         chk($sformatf("gap3_busy_%0d", i), {31'd0, busy3}, 32'h1);
      end
      tick();
      chk("handoff3_en", {28'd0, en3}, 32'h8);

      // Everything drops: DEAD then IDLE with BUSY low.
      req3 = 4'b0000;
      tick();
      chk("drop_en", {28'd0, en3}, 32'h0);
      chk("drop_busy", {31'd0, busy3}, 32'h1);
      tick();
      tick();
      chk("dead_end_busy", {31'd0, busy3}, 32'h1);
      tick();
      chk("idle_busy", {31'd0, busy3}, 32'h0);
      chk("idle_en", {28'd0, en3}, 32'h0);

      // Round robin with all requesting; last owner was 3 so 0 goes first.
      req3 = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         exp_en = 4'b0001 << k;
         tick();
         chk($sformatf("rr_grant_%0d", k), {28'd0, en3}, {28'd0, exp_en});
         tick();
         chk($sformatf("rr_hold_%0d", k), {28'd0, en3}, {28'd0, exp_en});
         req3 = 4'b1111 & ~exp_en;
         tick();
         chk($sformatf("rr_rel_%0d", k), {28'd0, en3}, 32'h0);
         req3 = 4'b1111;
         tick();
         chk($sformatf("rr_gapa_%0d", k), {28'd0, en3}, 32'h0);
         tick();
         chk($sformatf("rr_gapb_%0d", k), {28'd0, en3}, 32'h0);
      end
      tick();
      chk("rr_wrap", {28'd0, en3}, 32'h1);
      tick();
      chk("rr_wrap_hold", {28'd0, en3}, 32'h1);

      // Asynchronous reset between edges while owner 0 drives.
      #2;
      rn = 1'b0;
      #1;
      chk("async_rst_en", {28'd0, en3}, 32'h0);
      chk("async_rst_enbar", {28'd0, en_bar3}, 32'hF);
      chk("async_rst_busy", {31'd0, busy3}, 32'h0);
      rn   = 1'b1;
      req3 = 4'b0011;
      tick();
      chk("post_rst_grant", {28'd0, en3}, 32'h1);

      // Tenure limit (only when the feature is built in); REQ[1] waits throughout.
      for (int i = 1; i <= 7; i++) begin
         tick();
`ifdef GF180_TBUF_ARB_MAXHOLD_EN
         exp_en = (i <= 3) ? 4'b0001 : ((i < 7) ? 4'b0000 : 4'b0010);
`else
         exp_en = 4'b0001;
`endif
         chk($sformatf("maxhold_%0d", i), {28'd0, en3}, {28'd0, exp_en});
      end
      req3 = 4'b0000;

      // One-cycle gap instance: drop to IDLE through DEAD, then regrant without a gap.
      req1 = 4'b0001;
      tick();
      chk("d1_grant", {28'd0, en1}, 32'h1);
      req1 = 4'b0000;
      tick();
      chk("d1_rel_en", {28'd0, en1}, 32'h0);
      chk("d1_rel_busy", {31'd0, busy1}, 32'h1);
      tick();
      chk("d1_idle_busy", {31'd0, busy1}, 32'h0);
      chk("d1_idle_en", {28'd0, en1}, 32'h0);
      req1 = 4'b0001;
      tick();
      chk("d1_regrant", {28'd0, en1}, 32'h1);
      req1 = 4'b0010;
      tick();
      chk("d1_gap", {28'd0, en1}, 32'h0);
      tick();
      chk("d1_handoff", {28'd0, en1}, 32'h2);
      req1 = 4'b0000;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__tbuf_arb4.md
# gf180mcu_osu_sc_gp12t3v3__tbuf_arb4

Four-way round-robin bus-ownership controller that directly drives the EN/EN_BAR pin pairs of four gp12t3v3 tri-state buffers (tbuf_4) sharing one output net. Guarantees at most one buffer drives the net at any time. Inserts a programmable break-before-make dead gap on every ownership handoff, so two drivers never overlap during switching. Sits immediately upstream of the tbuf_4 bank; requesters sit upstream of this block.

## Interface
- DEAD_CYCLES, 1: number of all-off cycles inserted between two owners; legal range 1–7.
- MAX_HOLD, 16: maximum tenure in cycles while others are waiting; legal range 2–255; used only with the macro.
- CLK  input  1  single clock; all state updates on the rising edge.
- RN  input  1  reset, asynchronous, active-low.
- REQ  input  4  per-requester bus request, level-sensitive, sampled at CLK rise.
- EN  output  4  per-buffer enable; one-hot or zero; registered.
- EN_BAR  output  4  registered complement of EN; always exactly ~EN.
- GNT  output  4  grant to requesters; identical to EN.
- BUSY  output  1  high in DRIVE or DEAD.

## Operation
- States: IDLE (no driver), DRIVE (one owner enabled), DEAD (all off, counting the gap).
- Reset (RN low, asynchronous): EN=4'b0000, EN_BAR=4'b1111, GNT=0, BUSY=0, state=IDLE, last-owner pointer=3 (index 0 highest priority after reset), counters=0.
- Round-robin priority: search starts at (last_owner+1) mod 4 and wraps. The owner just released is always lowest priority.
- IDLE: if any REQ bit is set, grant the winner and go to DRIVE. Otherwise stay in IDLE.
- DRIVE: the owner keeps EN while its REQ is high. When the owner's REQ is low at an edge: clear EN, load the dead counter with DEAD_CYCLES, go to DEAD. Changes on non-owner REQ bits are ignored in DRIVE.
- DEAD: decrement the dead counter each cycle. On the final dead cycle, arbitrate on the REQ sampled at that edge. With a winner, assert its EN and go to DRIVE. With no winner, go to IDLE.
- An owner that re-requests during DEAD is eligible, but at lowest priority.
- Invariants: popcount(EN)≤1 in every cycle; EN_BAR==~EN; EN is never nonzero in IDLE or DEAD.
- Reset asserted mid-DRIVE or mid-DEAD: all buffers disabled immediately, with no wait for a clock.

## Timing
- IDLE→grant: REQ sampled high at edge t gives EN high after edge t (1-cycle latency). Dead gap does not apply from IDLE.
- Release: owner REQ sampled low at edge t gives EN=0 after edge t.
- Handoff: after release, EN==0 for exactly DEAD_CYCLES full cycles. The new owner's EN rises at edge t+DEAD_CYCLES.
- Simultaneous events:
  - Owner drops REQ in the same cycle another requester raises REQ: normal dead-gap handoff.
  - All REQ low at the end of DEAD: IDLE, with BUSY low on the following cycle.
- BUSY is registered and changes on the same edges as the state.

## Configuration
- Macro GF180_TBUF_ARB_MAXHOLD_EN.
- Defined:
  - A tenure counter clears on each grant and increments every DRIVE cycle.
  - When the count reaches MAX_HOLD and any non-owner REQ is high, the owner is released exactly as if its REQ had dropped: EN cleared, then DEAD.
  - The preempted owner gets lowest priority.
  - If no other request is pending, the counter saturates and the owner keeps the bus.
- Undefined: no tenure counter; MAX_HOLD is ignored; the owner holds the bus indefinitely while its REQ is high.

## Test plan
- Reset, then REQ=4'b0100 → EN=4'b0100 and EN_BAR=4'b1011 one cycle later; BUSY=1.
- Owner 2 holds, REQ switches to 4'b1001 at the same edge, DEAD_CYCLES=3 → EN=0 for 3 cycles, then EN=4'b1000 (index 3 is next after 2).
- REQ=4'b1111 held, each owner dropping after 2 cycles and re-raising → grant order 0,1,2,3,0 with a DEAD_CYCLES gap between each; popcount(EN)≤1 checked every cycle.
- RN pulsed low mid-DRIVE, between clock edges → EN=0 and EN_BAR=4'b1111 immediately; after release, first grant goes to index 0.
- Macro defined, MAX_HOLD=4, owner 0 holds forever, REQ[1] raised at cycle 1 → EN[0] drops after the 4th tenure cycle, then EN=4'b0010 after the dead gap. Macro undefined: EN[0] stays high indefinitely.
- DEAD_CYCLES=1, all REQ dropped during DEAD → IDLE; next REQ=4'b0001 → EN=4'b0001 after one cycle, with no gap.
